// File: rtl/fold_addr_pkg.sv
// Shared types and constants for the two-level fold address generator.
package fold_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fold_state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_REPEAT = 1'b1;

endpackage

// File: rtl/fold_counter.sv
// Loop index counter: counts 0..len-1 on enable and wraps to 0 after the terminal value.
module fold_counter
  import fold_addr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] idx,
  output logic             term
);

  logic [CNT_W-1:0] r_idx;

  assign idx  = r_idx;
  assign term = (r_idx == (len - 1'b1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_idx <= '0;
    end else if (en) begin
      r_idx <= term ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fold_address_generator.sv
// Walks a synapse-fold loop nested in a neuron-fold loop, emitting one address per
// accepted beat on a valid/ready stream, with last-inner-beat flag and a done pulse.
module fold_address_generator
  import fold_addr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  syn_fold,
  input  logic [CNT_W-1:0]  neu_fold,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              last_syn,
  output logic              busy,
  output logic              done
);

  fold_state_t       r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_syn_fold;
  logic [CNT_W-1:0]  r_neu_fold;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_hs;
  logic              w_clr;
  logic              w_syn_term;
  logic              w_neu_term;
  logic              w_neu_en;
  logic              w_final;

  assign w_hs     = r_addr_valid & addr_ready;
  assign w_clr    = (r_state != RUN);
  assign w_neu_en = w_hs & w_syn_term;
  assign w_final  = w_syn_term & w_neu_term;

  fold_counter #(.CNT_W(CNT_W)) u_syn_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_hs),
    .len  (r_syn_fold),
    .idx  (),
    .term (w_syn_term)
  );

  // Outer loop only steps when the inner loop wraps on an accepted beat.
  fold_counter #(.CNT_W(CNT_W)) u_neu_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_neu_en),
    .len  (r_neu_fold),
    .idx  (),
    .term (w_neu_term)
  );

  assign addr       = r_addr;
  assign addr_valid = r_addr_valid;
  assign last_syn   = r_addr_valid & w_syn_term;
  assign busy       = r_busy;
  assign done       = r_done;

  // Job configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_mode     <= mode;
      r_base     <= base_addr;
      r_syn_fold <= syn_fold;
      r_neu_fold <= neu_fold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (syn_fold == '0 || neu_fold == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= RUN;
              r_addr       <= base_addr;
              r_addr_valid <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_hs) begin
            if (w_final) begin
              r_state      <= DONE;
              r_addr_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else if (w_syn_term && r_mode == MODE_REPEAT) begin
              r_addr <= r_base;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_addr_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fold_address_generator.md
# fold_address_generator

Two-level fold address generator for the BNN compute array. It walks a synapse-fold inner loop nested inside a neuron-fold outer loop and presents one memory address per beat on a valid/ready stream. It also flags the last beat of each inner loop and pulses `done` at the end of the job. It sits between the layer controller, which issues `start` and fold sizes, and the weight/activation BRAM read ports. It replaces the single-loop, fixed-fold generator with runtime folds, backpressure and a repeat mode.

## Interface
- `ADDR_W`, 12: address width; all address arithmetic is modulo 2^ADDR_W.
- `CNT_W`, 8: width of fold-size inputs and loop counters.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: job request; sampled only in IDLE.
- `mode`  in  1: 0 = LINEAR (address runs through all neu_fold×syn_fold beats), 1 = REPEAT (address restarts at base for every neuron fold). Latched on start.
- `base_addr`  in  ADDR_W: first address. Latched on start.
- `syn_fold`  in  CNT_W: inner loop length. Latched on start.
- `neu_fold`  in  CNT_W: outer loop length. Latched on start.
- `addr`  out  ADDR_W: current address, registered.
- `addr_valid`  out  1: `addr` is valid.
- `addr_ready`  in  1: consumer accepts the beat when `addr_valid & addr_ready`.
- `last_syn`  out  1: current beat is the final inner-loop beat; qualified by `addr_valid`.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at job end.

## Operation
- States:
  - IDLE: `start` latches `mode`, `base_addr`, `syn_fold` and `neu_fold`, then goes to RUN. If either fold is 0, it goes to DONE instead and emits no beats.
  - RUN: emits beats.
  - DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Counters:
  - `syn_idx` runs 0..syn_fold-1.
  - `neu_idx` runs 0..neu_fold-1.
  - Both advance only on handshake. `syn_idx` wraps to 0 and increments `neu_idx` when `syn_idx == syn_fold-1`.
- Address update on handshake:
  - Non-final inner beat: addr+1.
  - Inner wrap in LINEAR: addr+1.
  - Inner wrap in REPEAT: base_addr.
- Wrap-around: addr 2^ADDR_W-1 followed by +1 gives 0. No error is raised.
- `last_syn` = (syn_idx == syn_fold-1).
- Final beat: handshake with syn_idx == syn_fold-1 and neu_idx == neu_fold-1. The next state is DONE and `addr_valid` drops.
- `start` in RUN or DONE is ignored and not queued.
- Fold and base inputs may change freely after `start` is sampled; only the latched copies are used.
- `rst` in any state: next cycle is IDLE, counters are 0 and all outputs are at reset values. An in-flight job is abandoned with no `done`.
- Reset values: `addr`=0, `addr_valid`=0, `last_syn`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at edge T (IDLE): at T+1, `busy`=1, `addr_valid`=1, `addr`=base_addr.
- Throughput: one beat per cycle while `addr_ready`=1.
- `addr_ready`=0: `addr`, `addr_valid` and `last_syn` hold stable.
- Final handshake at edge K: at K+1, `addr_valid`=0, `busy`=0, `done`=1. At K+2, IDLE. The earliest next accepted `start` is sampled at K+2.
- Zero-fold job: `start` at T gives `done`=1 at T+1. `addr_valid` never rises.
- Total beats = syn_fold × neu_fold. Minimum job latency, start to done, is beats+1 cycles.

## Structure
- Package `fold_addr_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - mode constants `MODE_LINEAR`=0 and `MODE_REPEAT`=1.
- Sub-module `fold_counter` (CNT_W):
  - Inputs: `clr`, `en`, `len`.
  - Outputs: `idx`, `term` (idx==len-1).
  - Wraps to 0 on `en & term`.
  - Instantiated twice, once for the syn loop and once for the neu loop. The neu instance's `en` is driven by the syn instance's `en & term`.
- The address register and FSM live in the top module.

## Test plan
- LINEAR, base=0x010, syn=3, neu=2, ready=1 → addrs 0x010..0x015 on 6 consecutive cycles. `last_syn` on 0x012 and 0x015. `done` 1 cycle after 0x015.
- REPEAT, base=0x100, syn=4, neu=3 → 0x100–0x103 repeated 3 times. `last_syn` every 4th beat. 12 beats total.
- Backpressure: random `addr_ready` (≈50%) on the LINEAR case → same address sequence; outputs hold stable while ready=0; `done` once.
- Wrap: base=0xFFE, syn=4, neu=1 → 0xFFE, 0xFFF, 0x000, 0x001.
- Zero fold: syn=0, neu=5 → no `addr_valid`; `done` at T+1. A second `start` asserted during that DONE cycle is ignored.
- Reset mid-job: assert `rst` after 3 beats of syn=8, neu=2 → all outputs 0 next cycle; no `done`. A fresh `start` then runs the full 16 beats.
